// File: rtl/program_loader_if.sv
// Boot byte stream in, memory write port out; the loader drives the master side.
interface program_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: LE length, N LE words written to BASE_ADDR upward, then an XOR checksum byte.
// One byte per cycle plus a one-cycle WRITE bubble per word; in_ready drops outside LEN/DATA/CHECK.
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  program_loader_if.master bus,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic [1:0]       error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q;
  logic [31:0] word_idx_q;
  logic [31:0] len_q;
  logic [31:0] word_buf_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [7:0]  xor_acc_q;
  logic [1:0]  error_q;

  logic        accept;
  logic        last_byte;
  logic        restart;
  logic        bad_len;
  logic        bad_sum;
  logic [31:0] len_next;
  logic [31:0] word_next;

  assign bus.in_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_byte    = (byte_cnt_q == 2'd3);
  assign restart      = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  // Bytes shift in from the top so the 4th byte leaves a little-endian word.
  assign len_next     = {bus.in_data, len_q[31:8]};
  assign word_next    = {bus.in_data, word_buf_q[31:8]};
  assign bad_len      = (len_next == 32'd0) || (len_next > MAX_WORDS);
  assign bad_sum      = (bus.in_data != xor_acc_q);

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign error         = error_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    bus.mem_we = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    core_reset = 1'b1;
    case (state_q)
      S_IDLE, S_ERROR: if (start) state_d = S_LEN;
      S_DONE: begin
        done       = 1'b1;
        core_reset = 1'b0;
        if (start) state_d = S_LEN;
      end
      S_LEN: begin
        busy = 1'b1;
        if (accept && last_byte) state_d = bad_len ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        if (accept && last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy       = 1'b1;
        bus.mem_we = 1'b1;
        state_d    = (word_idx_q + 32'd1 == len_q) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (accept) state_d = bad_sum ? S_ERROR : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_q  <= 2'd0;
      word_idx_q  <= 32'd0;
      len_q       <= 32'd0;
      word_buf_q  <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      xor_acc_q   <= 8'd0;
      error_q     <= 2'd0;
    end else begin
      if (restart) begin
        byte_cnt_q <= 2'd0;
        word_idx_q <= 32'd0;
        xor_acc_q  <= 8'd0;
        error_q    <= 2'd0;
      end
      // byte_cnt wraps naturally after each 4-byte group.
      if (accept && (state_q != S_CHECK)) byte_cnt_q <= byte_cnt_q + 2'd1;
      if (accept && (state_q == S_LEN)) begin
        len_q <= len_next;
        if (last_byte && bad_len) error_q <= 2'd1;
      end
      if (accept && (state_q == S_DATA)) begin
        word_buf_q <= word_next;
        xor_acc_q  <= xor_acc_q ^ bus.in_data;
        if (last_byte) begin
          mem_addr_q  <= BASE_ADDR + (word_idx_q << 2);
          mem_wdata_q <= word_next;
        end
      end
      if (state_q == S_WRITE) word_idx_q <= word_idx_q + 32'd1;
      if (accept && (state_q == S_CHECK) && bad_sum) error_q <= 2'd2;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; a second instance at BASE_ADDR 0x100 sees the same stimulus.
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic       core_reset, busy, done;
  logic [1:0] error;
  logic       core_reset2, busy2, done2;
  logic [1:0] error2;

  program_loader_if a_if();
  program_loader_if b_if();

  assign a_if.in_data  = in_data;
  assign a_if.in_valid = in_valid;
  assign b_if.in_data  = in_data;
  assign b_if.in_valid = in_valid;

  program_loader u_dut (
    .clk(clk), .reset(reset), .start(start), .bus(a_if),
    .core_reset(core_reset), .busy(busy), .done(done), .error(error)
  );

  program_loader #(.BASE_ADDR(32'h100)) u_dut_hi (
    .clk(clk), .reset(reset), .start(start), .bus(b_if),
    .core_reset(core_reset2), .busy(busy2), .done(done2), .error(error2)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          rdy_bad = 0;
  int          wr2_cnt = 0;
  logic [31:0] wr2_addr = 32'h0;

  always @(negedge clk) begin
    if (a_if.mem_we) begin
      wr_addr.push_back(a_if.mem_addr);
      wr_data.push_back(a_if.mem_wdata);
      if (a_if.in_ready) rdy_bad++;
    end
    if (b_if.mem_we) begin
      wr2_cnt++;
      wr2_addr = b_if.mem_addr;
    end
  end

  logic [7:0]  stream [17];
  logic [31:0] exp_data [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!a_if.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("rdy_timeout", guard, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int base);
    chk({tag, "_wcnt"}, wr_addr.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_addr"}, wr_addr[base + k], 32'(k * 4));
      chk({tag, "_data"}, wr_data[base + k], exp_data[k]);
    end
  endtask

  initial begin
    int base;
    int base2;
    stream = '{8'h03, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h01, 8'h00,
               8'h93, 8'h00, 8'h41, 8'h00,
               8'h93, 8'h00, 8'h81, 8'hff,
               8'hAD};
    exp_data = '{32'h00010093, 32'h00410093, 32'hff810093};

    #2 reset = 1'b0;
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_in_ready", a_if.in_ready, 0);
    chk("rst_mem_we", a_if.mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_mem_addr", a_if.mem_addr, 0);
    chk("rst_mem_wdata", a_if.mem_wdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Clean 3-word load, back-to-back bytes
    base = wr_addr.size();
    pulse_start();
    chk("a_busy", busy, 1);
    for (int i = 0; i < 17; i++) send_byte(stream[i], 0);
    check_writes("a", base);
    chk("a_done", done, 1);
    chk("a_core_reset", core_reset, 0);
    chk("a_error", error, 0);
    chk("a_rdy_in_write", rdy_bad, 0);

    // Restart from DONE, bad checksum
    base = wr_addr.size();
    pulse_start();
    chk("b_core_reset_next", core_reset, 1);
    chk("b_done_clr", done, 0);
    for (int i = 0; i < 16; i++) send_byte(stream[i], 0);
    send_byte(8'hAC, 0);
    check_writes("b", base);
    chk("b_error", error, 2);
    chk("b_core_reset", core_reset, 1);
    chk("b_done", done, 0);
    repeat (3) @(negedge clk);
    chk("b_error_sticky", error, 2);

    // Zero length
    base = wr_addr.size();
    pulse_start();
    chk("c_error_clr", error, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    chk("c_error", error, 1);
    chk("c_busy", busy, 0);
    chk("c_no_write", wr_addr.size() - base, 0);

    // Length MAX_WORDS+1 = 0x401
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("d_error", error, 1);
    chk("d_no_write", wr_addr.size() - base, 0);

    // 5-cycle valid gaps, with a start pulse mid-load that must be ignored
    base = wr_addr.size();
    pulse_start();
    for (int i = 0; i < 17; i++) begin
      if (i == 6) begin
        pulse_start();
        chk("e_busy_after_start", busy, 1);
      end
      send_byte(stream[i], 5);
    end
    check_writes("e", base);
    chk("e_done", done, 1);
    chk("e_error", error, 0);
    chk("e_rdy_in_write", rdy_bad, 0);

    // Reset during 2nd word's 3rd byte
    base = wr_addr.size();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(stream[i], 0);
    in_data  = stream[10];
    in_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("f_core_reset", core_reset, 1);
    chk("f_busy", busy, 0);
    chk("f_in_ready", a_if.in_ready, 0);
    chk("f_mem_we", a_if.mem_we, 0);
    chk("f_mem_addr", a_if.mem_addr, 0);
    chk("f_done", done, 0);
    chk("f_one_write", wr_addr.size() - base, 1);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    base = wr_addr.size();
    pulse_start();
    for (int i = 0; i < 17; i++) send_byte(stream[i], 0);
    check_writes("g", base);
    chk("g_done", done, 1);

    // From DONE: 1-word load, checksum EF^BE^AD^DE = 22
    chk("h_core_released", core_reset, 0);
    base  = wr_addr.size();
    base2 = wr2_cnt;
    pulse_start();
    chk("h_core_reset_next", core_reset, 1);
    chk("h_done_clr", done, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    send_byte(8'h22, 0);
    chk("h_wcnt", wr_addr.size() - base, 1);
    chk("h_addr", wr_addr[base], 32'h0);
    chk("h_data", wr_data[base], 32'hDEADBEEF);
    chk("h_hi_wcnt", wr2_cnt - base2, 1);
    chk("h_hi_addr", wr2_addr, 32'h100);
    chk("h_hi_done", done2, 1);
    chk("h_done", done, 1);
    chk("h_core_reset", core_reset, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time writer for the core's unified instruction/data memory. It is the producer side of the memory that fetch reads.
- Takes a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes them to consecutive word addresses, then verifies a checksum.
- Holds the core in reset until a load completes cleanly. Sits between the host/debug byte source and the memory write port, alongside utoss_riscv.

Parameters:
BASE_ADDR, 32'h0, byte address of the first loaded word (word-aligned)
MAX_WORDS, 1024, largest accepted word count N

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle
mem_we  output  1  memory write strobe, one cycle per word
mem_addr  output  32  byte address of the write
mem_wdata  output  32  word to write
core_reset  output  1  active-high reset to the core; 1 = core held
busy  output  1  load in progress (LEN, DATA, WRITE, CHECK)
done  output  1  load completed, core released
error  output  2  0 none, 1 bad length, 2 checksum mismatch

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; core_reset = 1.
  - in_ready, mem_we, busy, done = 0; error = 0; mem_addr = 0; mem_wdata = 0.
  - All counters, the length register and the checksum are 0.
- Byte transfer: a byte is accepted on a rising clk with in_valid && in_ready. in_ready is a registered-state decode: 1 only in LEN, DATA and CHECK.
- IDLE: start -> LEN. Clear byte_cnt, word_idx and xor_acc. error = 0.
- LEN: accept 4 bytes, little-endian, into N.
  - On the 4th byte, N == 0 or N > MAX_WORDS -> ERROR with error = 1.
  - Otherwise -> DATA.
- DATA: accept 4 bytes, little-endian, into the word buffer. Every byte is XORed into xor_acc. The 4th byte -> WRITE.
- WRITE, exactly one cycle:
  - mem_we = 1; mem_addr = BASE_ADDR + 4*word_idx (32-bit wrap); mem_wdata = assembled word.
  - in_ready = 0; word_idx increments.
  - Next state: CHECK if word_idx+1 == N, else DATA.
- CHECK: accept 1 byte. Byte == xor_acc -> DONE; otherwise -> ERROR with error = 2.
- DONE: core_reset = 0 and done = 1. Hold until start or reset.
- ERROR: core_reset = 1 and error holds (sticky). Hold until start or reset.
- start in DONE or ERROR:
  - -> LEN; core_reset reasserts the next cycle; done and error clear.
  - Counters clear as in IDLE.
- start while busy is ignored.
- mem_we is never asserted outside WRITE. A word is written only after all 4 of its bytes arrive.
- in_valid stalls (gaps of any length) pause the FSM with no side effects. Bytes presented while in_ready = 0 are not consumed.
- Reset mid-load: immediate return to IDLE with core_reset = 1 and mem_we = 0. Words already written stay in memory.
- Throughput: one byte per cycle in LEN/DATA/CHECK, plus one WRITE bubble per word.

Test Plan:
- Load 3 words. Stream 03 00 00 00, then 93 00 01 00, 93 00 41 00, 93 00 81 ff, then checksum AD.
  - Expected writes: 0x00010093 @0, 0x00410093 @4, 0xff810093 @8, three mem_we pulses total.
  - Then done = 1 and core_reset = 0.
  - Then release utoss_riscv: x1 = 34 after three instructions, with x2 preset to 42.
- Same stream with checksum AC -> error = 2, core_reset stays 1, done = 0, 3 writes still observed.
- Length 00 00 00 00 -> error = 1 after the 4th byte, no mem_we. Length MAX_WORDS+1 -> error = 1.
- Valid gaps: in_valid deasserted 5 cycles between every byte of the 3-word load. Expect identical writes/addresses and the WRITE cycle to have in_ready = 0.
- Reset low during the 2nd word's 3rd byte:
  - Outputs at reset values asynchronously and only 1 mem_we seen.
  - A subsequent start plus the full stream completes normally.
- start pulsed while busy has no effect. start in DONE reasserts core_reset the next cycle and a new 1-word load (BASE_ADDR = 0x100) writes @0x100.
